// File: rtl/msx_audio_mixer.sv
// -----------------------------------------------------------------------------
// msx_audio_mixer
//
// Time-multiplexed audio mixer for the MSX core. On each sample strobe the
// per-channel samples, gains and mutes are captured into shadow registers,
// then one channel per clock is converted to signed, scaled by its 4-bit
// gain (units of 1/8) and summed into a wide accumulator. A final stage
// shifts the sum back to the output scale and saturates it, flagging clips.
//
// Optional feature macro: MIXER_DCBLOCK_EN
//   When defined, a one-pole DC-blocking high-pass filter runs between the
//   shift and the clamp (extra FILT state, one extra cycle of latency).
//
// Parameters:
//   CHANNELS    number of input channels (1..16)
//   IN_W        width of each channel sample
//   OUT_W       output width (OUT_W <= IN_W)
//   SIGNED_MASK bit i = 1: channel i two's complement, 0: offset-binary
//
// Ports:
//   clk_sys     system clock
//   reset       synchronous, active-high reset
//   sample_stb  single-cycle pulse starting one mix
//   ch_data     channel samples, channel i at [i*IN_W +: IN_W]
//   ch_gain     4-bit unsigned gain per channel (8 = unity)
//   ch_mute     per-channel mute
//   busy        mix in progress
//   out_valid   single-cycle pulse when audio_out/clip update
//   audio_out   signed mixed sample, held between pulses
//   clip        last sample saturated
//   overrun     sticky: a strobe arrived while busy and was dropped
// -----------------------------------------------------------------------------
module msx_audio_mixer #(
  parameter int                  CHANNELS    = 4,
  parameter int                  IN_W        = 16,
  parameter int                  OUT_W       = 16,
  parameter logic [CHANNELS-1:0] SIGNED_MASK = {CHANNELS{1'b1}}
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     sample_stb,
  input  logic [CHANNELS*IN_W-1:0] ch_data,
  input  logic [CHANNELS*4-1:0]    ch_gain,
  input  logic [CHANNELS-1:0]      ch_mute,
  output logic                     busy,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         audio_out,
  output logic                     clip,
  output logic                     overrun
);

  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PROD_W = IN_W + 5;
  localparam int ACC_W  = IN_W + 5 + $clog2(CHANNELS);
  // Gain is in eighths, so 3 extra bits are dropped besides the width change.
  localparam int SHIFT  = 3 + IN_W - OUT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

`ifdef MIXER_DCBLOCK_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FILT  = 2'd2,
    S_SAT   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SAT   = 2'd2
  } state_t;
`endif

  state_t r_state;
  state_t w_state_next;
  logic   w_latch;
  logic   w_accum;
  logic   w_sat;
  logic   w_filt;

  logic [IDX_W-1:0]       r_idx;
  logic signed [ACC_W-1:0] r_acc;

  // Shadow copies of the inputs, captured on the accepted strobe.
  logic [IN_W-1:0]     r_data [CHANNELS];
  logic [3:0]          r_gain [CHANNELS];
  logic [CHANNELS-1:0] r_mute;

  logic signed [IN_W-1:0] w_conv [CHANNELS];

  logic                    r_out_valid;
  logic [OUT_W-1:0]        r_audio_out;
  logic                    r_clip;
  logic                    r_overrun;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_accum      = 1'b0;
    w_sat        = 1'b0;
    w_filt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sample_stb) begin
          w_latch      = 1'b1;
          w_state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_accum = 1'b1;
        if (r_idx == LAST_IDX) begin
`ifdef MIXER_DCBLOCK_EN
          w_state_next = S_FILT;
`else
          w_state_next = S_SAT;
`endif
        end
      end
`ifdef MIXER_DCBLOCK_EN
      S_FILT: begin
        w_filt       = 1'b1;
        w_state_next = S_SAT;
      end
`endif
      S_SAT: begin
        w_sat        = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Input capture and per-channel sign conversion
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (w_latch) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_data[i] <= ch_data[i*IN_W +: IN_W];
        r_gain[i] <= ch_gain[i*4 +: 4];
      end
      r_mute <= ch_mute;
    end
  end

  // Offset-binary becomes two's complement by flipping the MSB.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_conv
      assign w_conv[gi] = {r_data[gi][IN_W-1] ^ ~SIGNED_MASK[gi], r_data[gi][IN_W-2:0]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Multiply-accumulate, one channel per cycle
  // ---------------------------------------------------------------------------
  logic signed [IN_W-1:0]   w_sample;
  logic [3:0]               w_gain;
  logic                     w_mute;
  logic signed [PROD_W-1:0] w_samp_ext;
  logic signed [PROD_W-1:0] w_gain_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;

  assign w_sample   = w_conv[r_idx];
  assign w_gain     = r_gain[r_idx];
  assign w_mute     = r_mute[r_idx];
  assign w_samp_ext = PROD_W'(w_sample);
  assign w_gain_ext = PROD_W'(w_gain);
  assign w_prod     = w_mute ? '0 : (w_samp_ext * w_gain_ext);
  assign w_prod_ext = ACC_W'(w_prod);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_latch) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_accum) begin
      r_acc <= r_acc + w_prod_ext;
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  logic signed [ACC_W-1:0] w_shifted;
  logic signed [ACC_W-1:0] w_sat_src;

  assign w_shifted = r_acc >>> SHIFT;

`ifdef MIXER_DCBLOCK_EN
  // ---------------------------------------------------------------------------
  // DC blocker: y = x - x_prev + y_prev - (y_prev >>> 10)
  // State is two bits wider than the output; the input and the new state are
  // both pinned into that range so the recursion can never wrap.
  // ---------------------------------------------------------------------------
  localparam int F_W = OUT_W + 2;
  localparam int W_W = F_W + 3;
  localparam logic signed [ACC_W-1:0] F_MAX_A = ACC_W'((64'sd1 <<< (F_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] F_MIN_A = ACC_W'(-(64'sd1 <<< (F_W - 1)));
  localparam logic signed [W_W-1:0]   F_MAX_W = W_W'((64'sd1 <<< (F_W - 1)) - 64'sd1);
  localparam logic signed [W_W-1:0]   F_MIN_W = W_W'(-(64'sd1 <<< (F_W - 1)));

  logic signed [F_W-1:0] r_x_prev;
  logic signed [F_W-1:0] r_y_prev;
  logic signed [F_W-1:0] w_x_f;
  logic signed [F_W-1:0] w_y_f;
  logic signed [W_W-1:0] w_y_wide;

  always_comb begin
    w_x_f = F_W'(w_shifted);
    if (w_shifted > F_MAX_A) begin
      w_x_f = F_W'(F_MAX_A);
    end else if (w_shifted < F_MIN_A) begin
      w_x_f = F_W'(F_MIN_A);
    end
  end

  assign w_y_wide = W_W'(w_x_f) - W_W'(r_x_prev) + W_W'(r_y_prev) - W_W'(r_y_prev >>> 10);

  always_comb begin
    w_y_f = F_W'(w_y_wide);
    if (w_y_wide > F_MAX_W) begin
      w_y_f = F_W'(F_MAX_W);
    end else if (w_y_wide < F_MIN_W) begin
      w_y_f = F_W'(F_MIN_W);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_x_prev <= '0;
      r_y_prev <= '0;
    end else if (w_filt) begin
      r_x_prev <= w_x_f;
      r_y_prev <= w_y_f;
    end
  end

  assign w_sat_src = ACC_W'(r_y_prev);
`else
  assign w_sat_src = w_shifted;
`endif

  // ---------------------------------------------------------------------------
  // Saturation and outputs
  // ---------------------------------------------------------------------------
  logic                    w_clip_hi;
  logic                    w_clip_lo;
  logic signed [ACC_W-1:0] w_clamped;

  assign w_clip_hi = (w_sat_src > OUT_MAX);
  assign w_clip_lo = (w_sat_src < OUT_MIN);
  assign w_clamped = w_clip_hi ? OUT_MAX : (w_clip_lo ? OUT_MIN : w_sat_src);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_audio_out <= '0;
      r_clip      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= w_sat;
      if (w_sat) begin
        r_audio_out <= w_clamped[OUT_W-1:0];
        r_clip      <= w_clip_hi | w_clip_lo;
      end
      if (sample_stb && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign audio_out = r_audio_out;
  assign clip      = r_clip;
  assign overrun   = r_overrun;

endmodule
